// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//   Main control FSM for the multi-cycle MIPS datapath. It sequences fetch,
//   decode, execute, memory access and write-back, steers the shared ALU and
//   counts retired instructions.
//
// Ports
//   clk        system clock, rising-edge active
//   reset      synchronous, active-high reset
//   opcode     instr[31:26] from the instruction register
//   zero       ALU zero flag
//   memReady   memory completes the current access this cycle
//   iorD       memory address select: 0 = PC, 1 = ALUOut
//   memWrite   memory write strobe
//   irWrite    instruction register load
//   regDst     write register select: 0 = rt, 1 = rd
//   memToReg   write-back data select: 1 = MDR
//   regWrite   register file write enable
//   aluSrcA    ALU A select: 0 = PC, 1 = rs data
//   aluSrcB    ALU B select: 00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2
//   aluOp      to the ALU-control decoder: 00 add, 01 sub, 10 funct, 11 sltiu
//   pcSrc      next PC select: 00 ALU result, 01 ALUOut, 10 jump target
//   pcEn       PC register enable
//   illegalOp  one-cycle pulse in DECODE for an unsupported opcode
//   state      current state, for debug
//   instret    retired-instruction count (wraps)
// -----------------------------------------------------------------------------
module multicycle_control #(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               zero,
    input  logic               memReady,
    output logic               iorD,
    output logic               memWrite,
    output logic               irWrite,
    output logic               regDst,
    output logic               memToReg,
    output logic               regWrite,
    output logic               aluSrcA,
    output logic [1:0]         aluSrcB,
    output logic [1:0]         aluOp,
    output logic [1:0]         pcSrc,
    output logic               pcEn,
    output logic               illegalOp,
    output logic [3:0]         state,
    output logic [COUNT_W-1:0] instret
);

    localparam logic [3:0] FETCH   = 4'd0;
    localparam logic [3:0] DECODE  = 4'd1;
    localparam logic [3:0] MEMADR  = 4'd2;
    localparam logic [3:0] MEMRD   = 4'd3;
    localparam logic [3:0] MEMWB   = 4'd4;
    localparam logic [3:0] MEMWR   = 4'd5;
    localparam logic [3:0] EXECUTE = 4'd6;
    localparam logic [3:0] ALUWB   = 4'd7;
    localparam logic [3:0] BRANCH  = 4'd8;
    localparam logic [3:0] ADDIEX  = 4'd9;
    localparam logic [3:0] SLTIUEX = 4'd10;
    localparam logic [3:0] IMMWB   = 4'd11;
    localparam logic [3:0] JUMP    = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [3:0]         state_q, state_d;
    logic [COUNT_W-1:0] instret_q, instret_d;
    logic               pcWrite, branch, branchNe, retire;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d   = state_q;
        iorD      = 1'b0;
        memWrite  = 1'b0;
        irWrite   = 1'b0;
        regDst    = 1'b0;
        memToReg  = 1'b0;
        regWrite  = 1'b0;
        aluSrcA   = 1'b0;
        aluSrcB   = 2'b00;
        aluOp     = 2'b00;
        pcSrc     = 2'b00;
        illegalOp = 1'b0;
        pcWrite   = 1'b0;
        branch    = 1'b0;
        branchNe  = 1'b0;
        retire    = 1'b0;

        case (state_q)
            FETCH: begin
                // PC+4 computed every cycle; only committed once memory answers.
                aluSrcB = 2'b01;
                irWrite = memReady;
                pcWrite = memReady;
                if (memReady) state_d = DECODE;
            end
            DECODE: begin
                // Speculatively form the branch target into ALUOut.
                aluSrcB = 2'b11;
                case (opcode)
                    OP_RTYPE:      state_d = EXECUTE;
                    OP_LW, OP_SW:  state_d = MEMADR;
                    OP_BEQ, OP_BNE: state_d = BRANCH;
                    OP_ADDI:       state_d = ADDIEX;
                    OP_SLTIU:      state_d = SLTIUEX;
                    OP_J:          state_d = JUMP;
                    default: begin
                        illegalOp = 1'b1;
                        state_d   = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                iorD = 1'b1;
                if (memReady) state_d = MEMWB;
            end
            MEMWB: begin
                memToReg = 1'b1;
                regWrite = 1'b1;
                retire   = 1'b1;
                state_d  = FETCH;
            end
            MEMWR: begin
                iorD     = 1'b1;
                memWrite = 1'b1;
                if (memReady) begin
                    retire  = 1'b1;
                    state_d = FETCH;
                end
            end
            EXECUTE: begin
                aluSrcA = 1'b1;
                aluOp   = 2'b10;
                state_d = ALUWB;
            end
            ALUWB: begin
                regDst   = 1'b1;
                regWrite = 1'b1;
                retire   = 1'b1;
                state_d  = FETCH;
            end
            BRANCH: begin
                aluSrcA  = 1'b1;
                aluOp    = 2'b01;
                pcSrc    = 2'b01;
                branch   = (opcode == OP_BEQ);
                branchNe = (opcode == OP_BNE);
                retire   = 1'b1;
                state_d  = FETCH;
            end
            ADDIEX: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                state_d = IMMWB;
            end
            SLTIUEX: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                aluOp   = 2'b11;
                state_d = IMMWB;
            end
            IMMWB: begin
                regWrite = 1'b1;
                retire   = 1'b1;
                state_d  = FETCH;
            end
            JUMP: begin
                pcSrc   = 2'b10;
                pcWrite = 1'b1;
                retire  = 1'b1;
                state_d = FETCH;
            end
            // Unused codes 13-15 recover to FETCH.
            default: state_d = FETCH;
        endcase

        pcEn      = pcWrite | (branch & zero) | (branchNe & ~zero);
        // Natural modulo-2^COUNT_W wrap from the adder width.
        instret_d = retire ? instret_q + {{(COUNT_W-1){1'b0}}, 1'b1} : instret_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    assign state   = state_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//   Directed bench for multicycle_control. A 32-bit counter instance carries
//   the main table of per-cycle vectors; a 4-bit counter instance shares the
//   same stimulus and is used to observe the instret wrap.
//   Control outputs are compared as one packed word:
//   {iorD,memWrite,irWrite,regDst,memToReg,regWrite,aluSrcA,aluSrcB,aluOp,
//    pcSrc,pcEn,illegalOp}
// -----------------------------------------------------------------------------
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       memReady;

    always #5 clk = ~clk;

    // Wide instance
    logic        iorD, memWrite, irWrite, regDst, memToReg, regWrite, aluSrcA;
    logic [1:0]  aluSrcB, aluOp, pcSrc;
    logic        pcEn, illegalOp;
    logic [3:0]  state;
    logic [31:0] instret;

    multicycle_control #(.COUNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .memReady(memReady),
        .iorD(iorD), .memWrite(memWrite), .irWrite(irWrite), .regDst(regDst),
        .memToReg(memToReg), .regWrite(regWrite), .aluSrcA(aluSrcA),
        .aluSrcB(aluSrcB), .aluOp(aluOp), .pcSrc(pcSrc), .pcEn(pcEn),
        .illegalOp(illegalOp), .state(state), .instret(instret)
    );

    // Narrow-counter instance
    logic        n_iorD, n_memWrite, n_irWrite, n_regDst, n_memToReg, n_regWrite, n_aluSrcA;
    logic [1:0]  n_aluSrcB, n_aluOp, n_pcSrc;
    logic        n_pcEn, n_illegalOp;
    logic [3:0]  n_state;
    logic [3:0]  n_instret;

    multicycle_control #(.COUNT_W(4)) dut_n (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .memReady(memReady),
        .iorD(n_iorD), .memWrite(n_memWrite), .irWrite(n_irWrite), .regDst(n_regDst),
        .memToReg(n_memToReg), .regWrite(n_regWrite), .aluSrcA(n_aluSrcA),
        .aluSrcB(n_aluSrcB), .aluOp(n_aluOp), .pcSrc(n_pcSrc), .pcEn(n_pcEn),
        .illegalOp(n_illegalOp), .state(n_state), .instret(n_instret)
    );

    logic [14:0] ctrl, n_ctrl;
    assign ctrl   = {iorD, memWrite, irWrite, regDst, memToReg, regWrite, aluSrcA,
                     aluSrcB, aluOp, pcSrc, pcEn, illegalOp};
    assign n_ctrl = {n_iorD, n_memWrite, n_irWrite, n_regDst, n_memToReg, n_regWrite,
                     n_aluSrcA, n_aluSrcB, n_aluOp, n_pcSrc, n_pcEn, n_illegalOp};

    // Hand-derived control words:      io mw ir rd m2r rw sa  sb   op   ps  pe il
    localparam logic [14:0] C_FETCH1 = 15'b0__0__1__0__0__0__0__01__00__00__1__0;
    localparam logic [14:0] C_FETCH0 = 15'b0__0__0__0__0__0__0__01__00__00__0__0;
    localparam logic [14:0] C_DEC    = 15'b0__0__0__0__0__0__0__11__00__00__0__0;
    localparam logic [14:0] C_DECILL = 15'b0__0__0__0__0__0__0__11__00__00__0__1;
    localparam logic [14:0] C_EXEC   = 15'b0__0__0__0__0__0__1__00__10__00__0__0;
    localparam logic [14:0] C_ALUWB  = 15'b0__0__0__1__0__1__0__00__00__00__0__0;
    localparam logic [14:0] C_MEMADR = 15'b0__0__0__0__0__0__1__10__00__00__0__0;
    localparam logic [14:0] C_MEMRD  = 15'b1__0__0__0__0__0__0__00__00__00__0__0;
    localparam logic [14:0] C_MEMWB  = 15'b0__0__0__0__1__1__0__00__00__00__0__0;
    localparam logic [14:0] C_MEMWR  = 15'b1__1__0__0__0__0__0__00__00__00__0__0;
    localparam logic [14:0] C_BEQT   = 15'b0__0__0__0__0__0__1__00__01__01__1__0;
    localparam logic [14:0] C_BNEN   = 15'b0__0__0__0__0__0__1__00__01__01__0__0;
    localparam logic [14:0] C_SLTIU  = 15'b0__0__0__0__0__0__1__10__11__00__0__0;
    localparam logic [14:0] C_IMMWB  = 15'b0__0__0__0__0__1__0__00__00__00__0__0;
    localparam logic [14:0] C_JUMP   = 15'b0__0__0__0__0__0__0__00__00__10__1__0;

    typedef struct {
        logic [5:0]  op;
        logic        z;
        logic        mr;
        logic [3:0]  st;
        logic [14:0] ctl;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic add(input logic [5:0] op, input logic z, input logic mr,
                       input logic [3:0] st, input logic [14:0] ctl, input logic [31:0] cnt);
        vec_t v;
        v.op = op; v.z = z; v.mr = mr; v.st = st; v.ctl = ctl; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    // One cycle: drive inputs just after the edge, sample mid-cycle, advance.
    task automatic step(input logic [5:0] op, input logic z, input logic mr);
        opcode = op; zero = z; memReady = mr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; opcode = 6'd0; zero = 1'b0; memReady = 1'b1;
        tick(); tick();
        reset = 1'b0;

        // ---- Reset in the middle of a stalled load ----
        // j first so the counter is non-zero before the reset.
        step(6'b000010, 1'b0, 1'b1); tick();   // FETCH
        step(6'b000010, 1'b0, 1'b1); tick();   // DECODE
        step(6'b000010, 1'b0, 1'b1); tick();   // JUMP
        check("pre_reset instret", instret, 32'd1);
        step(6'b100011, 1'b0, 1'b1); tick();   // FETCH
        step(6'b100011, 1'b0, 1'b1); tick();   // DECODE
        step(6'b100011, 1'b0, 1'b1); tick();   // MEMADR
        step(6'b100011, 1'b0, 1'b0);           // MEMRD, memory stalled
        check("pre_reset state", {28'd0, state}, 32'd3);
        reset = 1'b1;
        tick(); tick();
        check("reset state", {28'd0, state}, 32'd0);
        check("reset instret", instret, 32'd0);
        check("reset ctrl", {17'd0, ctrl}, {17'd0, C_FETCH0});
        reset = 1'b0;
        step(6'b000000, 1'b0, 1'b1);
        check("first fetch ctrl", {17'd0, ctrl}, {17'd0, C_FETCH1});

        // ---- Table of per-cycle vectors, starting from this FETCH ----
        // R-type: 0,1,6,7
        add(6'b000000, 0, 1, 4'd0,  C_FETCH1, 0);
        add(6'b000000, 0, 1, 4'd1,  C_DEC,    0);
        add(6'b000000, 0, 1, 4'd6,  C_EXEC,   0);
        add(6'b000000, 0, 1, 4'd7,  C_ALUWB,  0);
        // lw, three stall cycles in MEMRD (8 cycles total)
        add(6'b100011, 0, 1, 4'd0,  C_FETCH1, 1);
        add(6'b100011, 0, 1, 4'd1,  C_DEC,    1);
        add(6'b100011, 0, 1, 4'd2,  C_MEMADR, 1);
        add(6'b100011, 0, 0, 4'd3,  C_MEMRD,  1);
        add(6'b100011, 0, 0, 4'd3,  C_MEMRD,  1);
        add(6'b100011, 0, 0, 4'd3,  C_MEMRD,  1);
        add(6'b100011, 0, 1, 4'd3,  C_MEMRD,  1);
        add(6'b100011, 0, 1, 4'd4,  C_MEMWB,  1);
        // beq taken
        add(6'b000100, 1, 1, 4'd0,  C_FETCH1, 2);
        add(6'b000100, 1, 1, 4'd1,  C_DEC,    2);
        add(6'b000100, 1, 1, 4'd8,  C_BEQT,   2);
        // bne with zero=1: not taken
        add(6'b000101, 1, 1, 4'd0,  C_FETCH1, 3);
        add(6'b000101, 1, 1, 4'd1,  C_DEC,    3);
        add(6'b000101, 1, 1, 4'd8,  C_BNEN,   3);
        // sltiu
        add(6'b001011, 0, 1, 4'd0,  C_FETCH1, 4);
        add(6'b001011, 0, 1, 4'd1,  C_DEC,    4);
        add(6'b001011, 0, 1, 4'd10, C_SLTIU,  4);
        add(6'b001011, 0, 1, 4'd11, C_IMMWB,  4);
        // j
        add(6'b000010, 0, 1, 4'd0,  C_FETCH1, 5);
        add(6'b000010, 0, 1, 4'd1,  C_DEC,    5);
        add(6'b000010, 0, 1, 4'd12, C_JUMP,   5);
        // illegal opcode: one-cycle pulse, not counted
        add(6'b111111, 0, 1, 4'd0,  C_FETCH1, 6);
        add(6'b111111, 0, 1, 4'd1,  C_DECILL, 6);
        // sw with one stall in FETCH and one in MEMWR
        add(6'b101011, 0, 0, 4'd0,  C_FETCH0, 6);
        add(6'b101011, 0, 1, 4'd0,  C_FETCH1, 6);
        add(6'b101011, 0, 1, 4'd1,  C_DEC,    6);
        add(6'b101011, 0, 1, 4'd2,  C_MEMADR, 6);
        add(6'b101011, 0, 0, 4'd5,  C_MEMWR,  6);
        add(6'b101011, 0, 1, 4'd5,  C_MEMWR,  6);
        // addi
        add(6'b001000, 0, 1, 4'd0,  C_FETCH1, 7);
        add(6'b001000, 0, 1, 4'd1,  C_DEC,    7);
        add(6'b001000, 0, 1, 4'd9,  C_MEMADR, 7);
        add(6'b001000, 0, 1, 4'd11, C_IMMWB,  7);
        add(6'b000000, 0, 1, 4'd0,  C_FETCH1, 8);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].op, vecs[i].z, vecs[i].mr);
            check($sformatf("row%0d state", i), {28'd0, state}, {28'd0, vecs[i].st});
            check($sformatf("row%0d ctrl", i), {17'd0, ctrl}, {17'd0, vecs[i].ctl});
            check($sformatf("row%0d instret", i), instret, vecs[i].cnt);
            check($sformatf("row%0d n_instret", i), {28'd0, n_instret},
                  {28'd0, vecs[i].cnt[3:0]});
            if (i != vecs.size() - 1) tick();
        end

        // ---- Counter wrap on the 4-bit instance: 15 jumps, then one more ----
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 16; k++) begin
            for (int c = 0; c < 3; c++) begin
                step(6'b000010, 1'b0, 1'b1);
                tick();
            end
            if (k == 14) begin
                check("wrap n_instret=15", {28'd0, n_instret}, 32'd15);
                check("wrap instret=15", instret, 32'd15);
            end
        end
        check("wrap n_instret=0", {28'd0, n_instret}, 32'd0);
        check("wrap instret=16", instret, 32'd16);
        check("wrap n_state", {28'd0, n_state}, 32'd0);
        check("wrap n_ctrl", {17'd0, n_ctrl}, {17'd0, C_FETCH1});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
